// File: rtl/packed_frame_streamer.sv
// packed_frame_streamer: multi-frame packed-pixel BRAM reader with a one-word cache.
// Define PREPROC_BINARIZE_EN to threshold pixels against the latched i_thresh.
module packed_frame_streamer #(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int PIX_BITS   = 8,
  parameter int WORD_BITS  = 64,
  parameter int ADDR_BITS  = 16,
  parameter int MAX_FRAMES = 16,
  parameter int BRAM_LAT   = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [ADDR_BITS-1:0]            i_base_addr,
  input  logic [$clog2(MAX_FRAMES+1)-1:0] i_num_frames,
  input  logic                            i_hflip,
  input  logic [PIX_BITS-1:0]             i_thresh,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_err,
  output logic                            o_bram_ena,
  output logic [ADDR_BITS-1:0]            o_bram_addr,
  input  logic [WORD_BITS-1:0]            i_bram_dout,
  output logic [PIX_BITS-1:0]             o_pix_data,
  output logic                            o_pix_valid,
  input  logic                            i_pix_ready,
  output logic                            o_line_end,
  output logic                            o_frame_end,
  output logic [$clog2(MAX_FRAMES)-1:0]   o_frame_idx
);

  localparam int PPW    = WORD_BITS / PIX_BITS;
  localparam int NPIX   = IMG_WIDTH * IMG_HEIGHT;
  localparam int WPF    = (NPIX + PPW - 1) / PPW;
  localparam int LG_PPW = $clog2(PPW);
  localparam int SW     = $clog2(NPIX + 1);
  localparam int CW     = $clog2(IMG_WIDTH + 1);
  localparam int RW     = $clog2(IMG_HEIGHT + 1);
  localparam int NW     = $clog2(MAX_FRAMES + 1);
  localparam int FW     = $clog2(MAX_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_STREAM, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_BITS-1:0] frame_addr;
  logic [NW-1:0]        cfg_nf;
  logic                 cfg_hflip;
  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic [SW-1:0]        row_base;
  logic [FW-1:0]        fidx;
  logic [1:0]           lat_cnt;
  logic [WORD_BITS-1:0] cache;
  logic [SW-1:0]        tag;
  logic                 err_q;

  logic                 nf_ok, can_go, go, bad;
  logic                 accept, lat_hit;
  logic                 last_col, last_row, last_frame, last_pix;
  logic [CW-1:0]        col_nx;
  logic [SW-1:0]        rb_nx, src, src_nx, word, word_nx;
  logic [WORD_BITS-1:0] shifted;
  logic [PIX_BITS-1:0]  raw_pix, pix;

  function automatic logic [SW-1:0] map_col(
    input logic [CW-1:0] c,
    input logic          flip
  );
    map_col = flip ? SW'(IMG_WIDTH - 1) - SW'(c) : SW'(c);
  endfunction

  assign nf_ok  = (i_num_frames != '0) &&
                  (i_num_frames <= NW'(MAX_FRAMES));
  assign can_go = start && (state == S_IDLE || state == S_DONE);
  assign go     = can_go && nf_ok;
  assign bad    = can_go && !nf_ok;
  assign accept = (state == S_STREAM) && i_pix_ready;
  assign lat_hit = lat_cnt == 2'(BRAM_LAT - 1);

  assign last_col   = col == CW'(IMG_WIDTH - 1);
  assign last_row   = row == RW'(IMG_HEIGHT - 1);
  assign last_frame = NW'(fidx) + NW'(1) == cfg_nf;
  assign last_pix   = last_col && last_row;

  assign src     = row_base + map_col(col, cfg_hflip);
  assign col_nx  = last_col ? '0 : col + CW'(1);
  assign rb_nx   = last_col ? row_base + SW'(IMG_WIDTH) : row_base;
  assign src_nx  = rb_nx + map_col(col_nx, cfg_hflip);
  assign word    = src >> LG_PPW;
  assign word_nx = src_nx >> LG_PPW;

  assign shifted = cache << ((32'(src) & 32'(PPW - 1)) * 32'(PIX_BITS));
  assign raw_pix = shifted[WORD_BITS-1 -: PIX_BITS];

`ifdef PREPROC_BINARIZE_EN
  logic [PIX_BITS-1:0] cfg_thresh;

  // latch the threshold with the rest of the run configuration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_thresh <= '0;
    else if (go) cfg_thresh <= i_thresh;
  end

  assign pix = (raw_pix >= cfg_thresh) ? '1 : '0;
`else
  logic unused_thresh;
  assign unused_thresh = ^i_thresh;
  assign pix = raw_pix;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  end

  // next-state: refetch on word change or new frame
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (go) state_nx = S_FETCH;
      S_FETCH: state_nx = S_WAIT;
      S_WAIT:  if (lat_hit) state_nx = S_STREAM;
      S_STREAM: begin
        if (accept) begin
          if (last_pix && last_frame) state_nx = S_DONE;
          else if (last_pix || word_nx != tag) state_nx = S_FETCH;
        end
      end
      S_DONE:  state_nx = go ? S_FETCH : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // output decode
  always_comb begin
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_bram_ena  = 1'b0;
    o_bram_addr = '0;
    o_pix_valid = 1'b0;
    o_pix_data  = '0;
    o_line_end  = 1'b0;
    o_frame_end = 1'b0;
    unique case (state)
      S_FETCH: begin
        o_busy      = 1'b1;
        o_bram_ena  = 1'b1;
        o_bram_addr = frame_addr + ADDR_BITS'(word);
      end
      S_WAIT: o_busy = 1'b1;
      S_STREAM: begin
        o_busy      = 1'b1;
        o_pix_valid = 1'b1;
        o_pix_data  = pix;
        o_line_end  = last_col;
        o_frame_end = last_pix;
      end
      S_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_frame_idx = fidx;
  assign o_err       = err_q;

  // position counters and run configuration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_addr <= '0;
      cfg_nf     <= '0;
      cfg_hflip  <= 1'b0;
      col        <= '0;
      row        <= '0;
      row_base   <= '0;
      fidx       <= '0;
    end else if (go) begin
      frame_addr <= i_base_addr;
      cfg_nf     <= i_num_frames;
      cfg_hflip  <= i_hflip;
      col        <= '0;
      row        <= '0;
      row_base   <= '0;
      fidx       <= '0;
    end else if (accept) begin
      col      <= col_nx;
      row_base <= rb_nx;
      if (last_col) row <= last_row ? '0 : row + RW'(1);
      if (last_pix) begin
        row_base <= '0;
        if (!last_frame) begin
          fidx       <= fidx + FW'(1);
          frame_addr <= frame_addr + ADDR_BITS'(WPF);
        end
      end
    end
  end

  // read-latency count and one-word cache fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt <= '0;
      cache   <= '0;
      tag     <= '0;
    end else if (state == S_FETCH) begin
      lat_cnt <= '0;
    end else if (state == S_WAIT) begin
      lat_cnt <= lat_cnt + 2'd1;
      if (lat_hit) begin
        cache <= i_bram_dout;
        tag   <= word;
      end
    end
  end

  // rejected-start pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else err_q <= bad;
  end

endmodule

// File: doc/packed_frame_streamer.md
Name: packed_frame_streamer

Overview:
- Multi-frame successor to the single-image loader and frame-reader path.
- Reads frames of packed pixels from the image BRAM, unpacks them through a one-word cache, and emits a valid/ready pixel stream with line_end and frame_end markers.
- Supports runtime base address, frame count and horizontal-flip mode.
- Feeds the Gaussian filter directly; it replaces the full-image register buffer.

Parameters:
- IMG_WIDTH, 28, pixels per row.
- IMG_HEIGHT, 28, rows per frame.
- PIX_BITS, 8, bits per pixel; power of two.
- WORD_BITS, 64, BRAM word width; power of two, at least PIX_BITS.
- ADDR_BITS, 16, BRAM word-address width.
- MAX_FRAMES, 16, largest accepted i_num_frames.
- BRAM_LAT, 1, cycles from the ena/addr sample to a valid i_bram_dout; 1 or 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle run request; ignored while o_busy=1.
- i_base_addr  in  ADDR_BITS  word address of frame 0.
- i_num_frames  in  $clog2(MAX_FRAMES+1)  frames to stream.
- i_hflip  in  1  reverse column order within each row.
- i_thresh  in  PIX_BITS  binarize threshold; used only with the optional feature.
- o_busy  out  1  run in progress.
- o_done  out  1  one-cycle pulse after the last pixel of the last frame is accepted.
- o_err  out  1  one-cycle pulse on a rejected start.
- o_bram_ena  out  1  BRAM read enable.
- o_bram_addr  out  ADDR_BITS  BRAM word address.
- i_bram_dout  in  WORD_BITS  BRAM read data.
- o_pix_data  out  PIX_BITS  pixel.
- o_pix_valid  out  1  pixel valid.
- i_pix_ready  in  1  downstream ready.
- o_line_end  out  1  qualifies the last pixel of a row.
- o_frame_end  out  1  qualifies the last pixel of a frame.
- o_frame_idx  out  $clog2(MAX_FRAMES)  index of the frame being streamed.

Behaviour:
- Derived constants:
  - PPW = WORD_BITS/PIX_BITS.
  - NPIX = IMG_WIDTH*IMG_HEIGHT.
  - WPF = ceil(NPIX/PPW).
  - Frame f occupies words i_base_addr + f*WPF onward. Address arithmetic wraps modulo 2^ADDR_BITS.
- Packing: image pixel index p sits in word p/PPW, lane p%PPW. Lane 0 is the most significant PIX_BITS of the word.
- Output order: row-major. Column c maps to source index row*IMG_WIDTH + (i_hflip ? IMG_WIDTH-1-c : c).
- Configuration capture: base address, frame count, flip mode and threshold are latched at start.
- Reset state: every output is 0 and the FSM is in IDLE. Reset mid-run aborts immediately; no done pulse is produced.
- IDLE:
  - start with 1 <= i_num_frames <= MAX_FRAMES: go to FETCH and set o_busy=1 on the next cycle.
  - Any other start: pulse o_err for one cycle and stay in IDLE.
- FETCH: drive o_bram_ena=1 and o_bram_addr = needed word for exactly one cycle, then go to WAIT.
- WAIT: count BRAM_LAT cycles, capture i_bram_dout into the cache and its address tag, then go to STREAM.
- STREAM:
  - o_pix_valid=1 with the cached lane.
  - On valid&&ready, advance column, row and frame.
  - If the next pixel's word differs from the tag, go to FETCH; otherwise continue, at one pixel per cycle.
- Stall rules: while valid && !ready, o_pix_data, o_line_end, o_frame_end and o_frame_idx hold stable, and no BRAM read is issued.
- Frame boundary: when the last pixel is accepted with frames remaining, o_frame_idx increments and the next frame's first word is fetched. The cache is never reused across frames.
- Run end: when the final pixel is accepted, go to DONE, which pulses o_done for one cycle, clears o_busy, and returns to IDLE.
- Latency:
  - First o_pix_valid at most BRAM_LAT+3 cycles after start is sampled.
  - A cache miss inserts at most BRAM_LAT+2 bubble cycles.
- Word straddling: rows are not word-aligned. The hflip miss pattern follows the per-pixel word comparison; there is no prefetch.
- o_bram_ena is 0 outside FETCH.

Optional Feature:
- Macro: PREPROC_BINARIZE_EN.
- Defined: o_pix_data = (pixel >= latched i_thresh) ? all ones : 0. Timing is unchanged.
- Undefined: raw pixels are output and i_thresh is ignored.

Test Plan:
1. 28x28, 8b/64b, base 0, 1 frame, ready=1, word n holds bytes 8n..8n+7 -> 784 pixels valued p mod 256 in order, line_end every 28th, frame_end on the 784th, 98 BRAM reads, single o_done.
2. Same with i_hflip=1 -> row 0 outputs 27,26,...,0; row 1 starts with 55; line_end on the pixel carrying value 0, 28, and so on.
3. Random ready at 50% duty -> outputs stable across every stall, 784 accepted, order as in scenario 1, no BRAM read while stalled.
4. base 100, 3 frames -> addresses 100..393, o_frame_idx 0/1/2, 3 frame_end pulses, one o_done.
5. i_num_frames=0 and =17 -> one o_err pulse each, o_busy stays 0; start asserted mid-run is ignored.
6. rst_n low at pixel 300 -> all outputs 0 next cycle, no o_done; a new start restarts from pixel 0 of frame 0.
